cov_monitor: RTL and testbench
==============================

COV_MONITOR -- requirements
Module: cov_monitor

Interface
REQ-001 Parameter CNT_W, default 8, width of each hit counter.
REQ-002 Parameter SYNC_TO, default 4, cycles allowed in SYNC before a missing out3 pulse is an error.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RSTn  input  1  asynchronous, active-low reset.
REQ-005 a, b, c  input  1 each  stimulus bits driven into the monitored block.
REQ-006 out1, out2, out3  input  1 each  response bits from the monitored block.
REQ-007 clr  input  1  synchronous clear of all statistics, errors and the sequence FSM.
REQ-008 cnt_out1, cnt_out2, cnt_out3  output  CNT_W each  saturating counts of cycles with that response high.
REQ-009 bins_hit  output  8  bit k set once {a,b,c}==k has been sampled (a is MSB).
REQ-010 all_bins  output  1  high when bins_hit==8'hFF.
REQ-011 locked  output  1  high while the sequence FSM is phase-locked to out3.
REQ-012 err_comb  output  1  sticky: out1/out2 mismatch seen.
REQ-013 err_seq  output  1  sticky: out3 period violation seen.

Function
REQ-014 Every posedge with RSTn high and clr low SHALL sample all inputs; results are visible after that edge (latency 1 cycle).
REQ-015 Expected out1 = a&b&c and expected out2 = a&b&~c, both from the same sample; any mismatch SHALL set err_comb.
REQ-016 cnt_outN SHALL increment by 1 when outN is sampled high and hold at 2^CNT_W-1 (no wrap).
REQ-017 bins_hit[{a,b,c}] SHALL be set on each sample; bits are never cleared except by reset or clr.
REQ-018 Sequence FSM states: SYNC, E0A, E0B, E1; reference period is out3 = 1,0,0,1,0,0,...
REQ-019 SYNC: out3=1 -> E0A; out3=0 -> stay and increment a timeout counter; the SYNC_TO-th consecutive 0 SHALL set err_seq and restart the timeout count.
REQ-020 E0A: out3=0 -> E0B; out3=1 -> err_seq, SYNC.
REQ-021 E0B: out3=0 -> E1; out3=1 -> err_seq, SYNC.
REQ-022 E1: out3=1 -> E0A; out3=0 -> err_seq, SYNC.
REQ-023 locked SHALL be 1 in E0A, E0B, E1 and 0 in SYNC.
REQ-024 The timeout counter SHALL clear on entry to SYNC and whenever out3=1 is sampled.
REQ-025 Entering SYNC on an error SHALL take effect on the same edge that sets err_seq; that out3 value is not reused to resync.
REQ-026 clr high SHALL take priority over sampling: on that edge counters, bins_hit, err_comb, err_seq and the timeout counter go to 0 and the FSM to SYNC.
REQ-027 err_comb and err_seq SHALL remain set until reset or clr, regardless of later correct behaviour.

Reset
REQ-028 RSTn low SHALL immediately force all counters 0, bins_hit 0, all_bins 0, locked 0, err_comb 0, err_seq 0, FSM SYNC, timeout counter 0.
REQ-029 Reset asserted mid-sequence SHALL discard phase; after release the FSM resyncs on the next out3=1.
REQ-030 No output SHALL change on the first posedge while RSTn is still low.

Verification
REQ-031 Release reset, drive out3 0,0,1,0,0,1,0,0,1 -> locked=1 from the cycle after the first 1, err_seq=0, cnt_out3=3.
REQ-032 Locked, then out3 0,1 (period 2) -> err_seq=1 and locked=0 on that edge; next out3=1 relocks while err_seq stays 1.
REQ-033 Sweep {a,b,c} 0..7 with correct out1/out2 -> bins_hit=8'hFF, all_bins=1, err_comb=0, cnt_out1=1, cnt_out2=1.
REQ-034 a=b=c=1 with out1=0 for one cycle -> err_comb=1 next cycle, held through 10 correct cycles.
REQ-035 out1 held high for 300 cycles with CNT_W=8 -> cnt_out1 saturates at 255; assert clr -> all statistics 0, locked=0.
REQ-036 Out3 stuck 0 after reset with SYNC_TO=4 -> err_seq=1 after the 4th sample, locked=0; RSTn pulse low -> all outputs 0.

Source files
------------

// File: rtl/cov_monitor_if.sv
// Signal bundle between a stimulus/response source and the coverage monitor.
// The master side drives stimulus, responses and clr; the slave side returns statistics.
interface cov_monitor_if #(
    parameter int CNT_W = 8
);
    logic             a;
    logic             b;
    logic             c;
    logic             out1;
    logic             out2;
    logic             out3;
    logic             clr;
    logic [CNT_W-1:0] cnt_out1;
    logic [CNT_W-1:0] cnt_out2;
    logic [CNT_W-1:0] cnt_out3;
    logic [7:0]       bins_hit;
    logic             all_bins;
    logic             locked;
    logic             err_comb;
    logic             err_seq;

    modport master (
        output a, b, c, out1, out2, out3, clr,
        input  cnt_out1, cnt_out2, cnt_out3, bins_hit, all_bins, locked, err_comb, err_seq
    );

    modport slave (
        input  a, b, c, out1, out2, out3, clr,
        output cnt_out1, cnt_out2, cnt_out3, bins_hit, all_bins, locked, err_comb, err_seq
    );
endinterface

// File: rtl/cov_monitor.sv
// Coverage/protocol monitor: checks out1/out2 against a,b,c, counts response hits,
// records input bins and tracks phase lock to a period-3 out3 pulse train.
module cov_monitor #(
    parameter int CNT_W   = 8,
    parameter int SYNC_TO = 4
) (
    input  logic            CLK,
    input  logic            RSTn,
    cov_monitor_if.slave    bus
);
    localparam int TO_W = (SYNC_TO > 1) ? $clog2(SYNC_TO) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TO - 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        E0A  = 2'd1,
        E0B  = 2'd2,
        E1   = 2'd3
    } seq_state_e;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
        logic [CNT_W-1:0] r;
        if (hit && (v != {CNT_W{1'b1}})) begin
            r = v + CNT_W'(1'b1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [CNT_W-1:0] cnt2_q, cnt2_d;
    logic [CNT_W-1:0] cnt3_q, cnt3_d;
    logic [7:0]       bins_q, bins_d;
    logic             all_bins_q, all_bins_d;
    logic             err_comb_q, err_comb_d;
    logic             err_seq_q, err_seq_d;
    logic             locked_q, locked_d;
    seq_state_e       state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             seq_err_s;
    logic             comb_err_s;
    logic [2:0]       abc_s;

    assign abc_s      = {bus.a, bus.b, bus.c};
    assign comb_err_s = (bus.out1 != (bus.a & bus.b & bus.c)) ||
                        (bus.out2 != (bus.a & bus.b & ~bus.c));

    // Sequence FSM next state and timeout counter.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        seq_err_s = 1'b0;
        if (bus.clr) begin
            state_d  = SYNC;
            to_cnt_d = '0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (bus.out3) begin
                        state_d  = E0A;
                        to_cnt_d = '0;
                    end else if (to_cnt_q == TO_LAST) begin
                        seq_err_s = 1'b1;
                        to_cnt_d  = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1'b1);
                    end
                end
                E0A, E0B: begin
                    if (bus.out3) begin
                        seq_err_s = 1'b1;
                        state_d   = SYNC;
                        to_cnt_d  = '0;
                    end else begin
                        state_d = (state_q == E0A) ? E0B : E1;
                    end
                end
                E1: begin
                    to_cnt_d = '0;
                    if (bus.out3) begin
                        state_d = E0A;
                    end else begin
                        seq_err_s = 1'b1;
                        state_d   = SYNC;
                    end
                end
                default: begin
                    state_d  = SYNC;
                    to_cnt_d = '0;
                end
            endcase
        end
    end

    // Statistics and sticky error next state; clr wins over sampling.
    always_comb begin
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        cnt3_d     = cnt3_q;
        bins_d     = bins_q;
        err_comb_d = err_comb_q;
        err_seq_d  = err_seq_q;
        if (bus.clr) begin
            cnt1_d     = '0;
            cnt2_d     = '0;
            cnt3_d     = '0;
            bins_d     = 8'h00;
            err_comb_d = 1'b0;
            err_seq_d  = 1'b0;
        end else begin
            cnt1_d           = sat_inc(cnt1_q, bus.out1);
            cnt2_d           = sat_inc(cnt2_q, bus.out2);
            cnt3_d           = sat_inc(cnt3_q, bus.out3);
            bins_d[abc_s]    = 1'b1;
            err_comb_d       = err_comb_q | comb_err_s;
            err_seq_d        = err_seq_q | seq_err_s;
        end
        all_bins_d = (bins_d == 8'hFF);
        locked_d   = (state_d != SYNC);
    end

    // State registers; all outputs come straight from these flops.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            cnt3_q     <= '0;
            bins_q     <= 8'h00;
            all_bins_q <= 1'b0;
            err_comb_q <= 1'b0;
            err_seq_q  <= 1'b0;
            locked_q   <= 1'b0;
            state_q    <= SYNC;
            to_cnt_q   <= '0;
        end else begin
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            cnt3_q     <= cnt3_d;
            bins_q     <= bins_d;
            all_bins_q <= all_bins_d;
            err_comb_q <= err_comb_d;
            err_seq_q  <= err_seq_d;
            locked_q   <= locked_d;
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign bus.cnt_out1 = cnt1_q;
    assign bus.cnt_out2 = cnt2_q;
    assign bus.cnt_out3 = cnt3_q;
    assign bus.bins_hit = bins_q;
    assign bus.all_bins = all_bins_q;
    assign bus.locked   = locked_q;
    assign bus.err_comb = err_comb_q;
    assign bus.err_seq  = err_seq_q;
endmodule

// File: tb/tb_cov_monitor.sv
// Directed self-checking bench for cov_monitor (CNT_W=8, SYNC_TO=4).
module tb_cov_monitor;
    logic CLK;
    logic RSTn;
    int   n_cmp;
    int   n_bad;

    cov_monitor_if #(.CNT_W(8)) bus ();

    cov_monitor #(.CNT_W(8), .SYNC_TO(4)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] abc, input logic o1, input logic o2, input logic o3);
        bus.a    = abc[2];
        bus.b    = abc[1];
        bus.c    = abc[0];
        bus.out1 = o1;
        bus.out2 = o2;
        bus.out3 = o3;
        step();
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        step();
        step();
        RSTn = 1'b1;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        bus.clr = 1'b0;
        drive(3'b100, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (bus.cnt_out1 !== 8'd0 || bus.cnt_out3 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: actual %0d/%0d required 0/0", bus.cnt_out1, bus.cnt_out3);
        end
        n_cmp++;
        if ({bus.bins_hit, bus.all_bins, bus.locked, bus.err_comb, bus.err_seq} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_flags: actual bins=%h ab=%b lk=%b ec=%b es=%b required all 0",
                     bus.bins_hit, bus.all_bins, bus.locked, bus.err_comb, bus.err_seq);
        end
        RSTn = 1'b1;
    endtask

    task automatic test_lock();
        for (int i = 0; i < 9; i++) begin
            drive(3'b000, 1'b0, 1'b0, (i % 3) == 2);
            if (i == 1) begin
                n_cmp++;
                if (bus.locked !== 1'b0) begin
                    n_bad++;
                    $display("FAIL lock_before: actual %b required 0", bus.locked);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if (bus.locked !== 1'b1) begin
                    n_bad++;
                    $display("FAIL lock_first: actual %b required 1", bus.locked);
                end
            end
        end
        n_cmp++;
        if (bus.err_seq !== 1'b0 || bus.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_end: actual es=%b lk=%b required es=0 lk=1", bus.err_seq, bus.locked);
        end
        n_cmp++;
        if (bus.cnt_out3 !== 8'd3) begin
            n_bad++;
            $display("FAIL lock_cnt3: actual %0d required 3", bus.cnt_out3);
        end
    endtask

    task automatic test_period_err();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.err_seq !== 1'b1 || bus.locked !== 1'b0) begin
            n_bad++;
            $display("FAIL period_err: actual es=%b lk=%b required es=1 lk=0", bus.err_seq, bus.locked);
        end
        drive(3'b000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.err_seq !== 1'b1 || bus.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL relock: actual es=%b lk=%b required es=1 lk=1", bus.err_seq, bus.locked);
        end
        n_cmp++;
        if (bus.cnt_out3 !== 8'd5) begin
            n_bad++;
            $display("FAIL relock_cnt3: actual %0d required 5", bus.cnt_out3);
        end
    endtask

    task automatic test_reset_midseq();
        RSTn = 1'b0;
        #1;
        n_cmp++;
        if (bus.locked !== 1'b0 || bus.err_seq !== 1'b0 || bus.cnt_out3 !== 8'd0) begin
            n_bad++;
            $display("FAIL async_reset: actual lk=%b es=%b c3=%0d required 0/0/0",
                     bus.locked, bus.err_seq, bus.cnt_out3);
        end
        step();
        RSTn = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.locked !== 1'b0) begin
            n_bad++;
            $display("FAIL midseq_nophase: actual %b required 0", bus.locked);
        end
        drive(3'b000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL midseq_resync: actual %b required 1", bus.locked);
        end
    endtask

    task automatic test_bins();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(3'(k), k == 7, k == 6, 1'b0);
            if (k == 3) begin
                n_cmp++;
                if (bus.bins_hit !== 8'h0F || bus.all_bins !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bins_partial: actual %h/%b required 0f/0", bus.bins_hit, bus.all_bins);
                end
            end
        end
        n_cmp++;
        if (bus.bins_hit !== 8'hFF || bus.all_bins !== 1'b1) begin
            n_bad++;
            $display("FAIL bins_full: actual %h/%b required ff/1", bus.bins_hit, bus.all_bins);
        end
        n_cmp++;
        if (bus.err_comb !== 1'b0) begin
            n_bad++;
            $display("FAIL bins_errcomb: actual %b required 0", bus.err_comb);
        end
        n_cmp++;
        if (bus.cnt_out1 !== 8'd1 || bus.cnt_out2 !== 8'd1) begin
            n_bad++;
            $display("FAIL bins_cnt12: actual %0d/%0d required 1/1", bus.cnt_out1, bus.cnt_out2);
        end
    endtask

    task automatic test_comb_err();
        do_clr();
        drive(3'b111, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.err_comb !== 1'b1) begin
            n_bad++;
            $display("FAIL comb_out1: actual %b required 1", bus.err_comb);
        end
        for (int i = 0; i < 10; i++) begin
            drive(3'b111, 1'b1, 1'b0, 1'b0);
        end
        n_cmp++;
        if (bus.err_comb !== 1'b1) begin
            n_bad++;
            $display("FAIL comb_sticky: actual %b required 1", bus.err_comb);
        end
        do_clr();
        drive(3'b110, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.err_comb !== 1'b0) begin
            n_bad++;
            $display("FAIL comb_out2_ok: actual %b required 0", bus.err_comb);
        end
        drive(3'b110, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.err_comb !== 1'b1) begin
            n_bad++;
            $display("FAIL comb_out2: actual %b required 1", bus.err_comb);
        end
    endtask

    task automatic test_saturate();
        do_clr();
        for (int i = 0; i < 300; i++) begin
            drive(3'b111, 1'b1, 1'b0, (i % 3) == 0);
            if (i == 253) begin
                n_cmp++;
                if (bus.cnt_out1 !== 8'd254) begin
                    n_bad++;
                    $display("FAIL sat_pre: actual %0d required 254", bus.cnt_out1);
                end
            end
        end
        n_cmp++;
        if (bus.cnt_out1 !== 8'd255 || bus.cnt_out3 !== 8'd100) begin
            n_bad++;
            $display("FAIL sat_hold: actual c1=%0d c3=%0d required 255/100", bus.cnt_out1, bus.cnt_out3);
        end
        n_cmp++;
        if (bus.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_locked: actual %b required 1", bus.locked);
        end
        bus.clr = 1'b1;
        drive(3'b000, 1'b1, 1'b1, 1'b1);
        bus.clr = 1'b0;
        n_cmp++;
        if (bus.cnt_out1 !== 8'd0 || bus.cnt_out2 !== 8'd0 || bus.cnt_out3 !== 8'd0) begin
            n_bad++;
            $display("FAIL clr_cnt: actual %0d/%0d/%0d required 0/0/0",
                     bus.cnt_out1, bus.cnt_out2, bus.cnt_out3);
        end
        n_cmp++;
        if ({bus.bins_hit, bus.all_bins, bus.locked, bus.err_comb, bus.err_seq} !== 12'h000) begin
            n_bad++;
            $display("FAIL clr_flags: actual bins=%h ab=%b lk=%b ec=%b es=%b required all 0",
                     bus.bins_hit, bus.all_bins, bus.locked, bus.err_comb, bus.err_seq);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (bus.err_seq !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: actual %b required 0", bus.err_seq);
        end
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.err_seq !== 1'b1 || bus.locked !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_4th: actual es=%b lk=%b required es=1 lk=0", bus.err_seq, bus.locked);
        end
        for (int i = 0; i < 4; i++) begin
            drive(3'b000, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (bus.err_seq !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: actual %b required 1", bus.err_seq);
        end
        RSTn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.cnt_out1, bus.cnt_out2, bus.cnt_out3, bus.bins_hit, bus.all_bins,
             bus.locked, bus.err_comb, bus.err_seq} !== 36'h0) begin
            n_bad++;
            $display("FAIL timeout_rst: actual es=%b bins=%h c1=%0d required all 0",
                     bus.err_seq, bus.bins_hit, bus.cnt_out1);
        end
        step();
        RSTn = 1'b1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        RSTn     = 1'b0;
        bus.clr  = 1'b0;
        bus.a    = 1'b0;
        bus.b    = 1'b0;
        bus.c    = 1'b0;
        bus.out1 = 1'b0;
        bus.out2 = 1'b0;
        bus.out3 = 1'b0;
        #2;
        test_reset();
        test_lock();
        test_period_err();
        test_reset_midseq();
        test_bins();
        test_comb_err();
        test_saturate();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
